// File: rtl/rtmc_spi_reg_bridge.sv
// SPI-slave (mode 0) to parallel register-bus bridge: 32-bit frames of
// command/address/data issue single-strobe reads or writes held until ack or timeout.
module rtmc_spi_reg_bridge #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdat,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdat,
    input  logic              reg_ack
);

    localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {FrIdle, FrCmd, FrAddr, FrData, FrDone} frame_e;
    typedef enum logic [1:0] {BusIdle, BusRd, BusWr} bus_e;

    // Synchronizers reset low so a reset taken with cs already low cannot
    // fake a cs falling edge and resume a frame half way through.
    logic [2:0] sclk_q, cs_q;
    logic [1:0] mosi_q;
    logic       sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;

    frame_e              frame_q, frame_d;
    bus_e                bus_q, bus_d;
    logic [5:0]          bit_cnt_q;
    logic [DATA_W-2:0]   rx_sr_q;
    logic                cmd_wr_q;
    logic [ADDR_W-1:0]   frame_addr_q;
    logic                rd_pend_q, wr_pend_q;
    logic [ADDR_W-1:0]   rd_addr_q, wr_addr_q, reg_addr_q;
    logic [DATA_W-1:0]   wr_data_q, reg_wdat_q;
    logic [DATA_W-1:0]   tx_sr_q;
    logic                tx_vld_q, miso_q;
    logic [TmoW-1:0]     tmo_q, tmo_d;
    logic                bit_rx, load_wr, load_rd, cap_rd, cap_zero;
    logic [ADDR_W-1:0]   addr_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            cs_q   <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_sclk};
            cs_q   <= {cs_q[1:0], spi_cs};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign mosi_s    = mosi_q[1];

    assign bit_rx   = sclk_rise && !cs_rise &&
                      (frame_q == FrCmd || frame_q == FrAddr || frame_q == FrData);
    assign addr_now = {rx_sr_q[ADDR_W-2:0], mosi_s};

    always_comb begin
        frame_d = frame_q;
        unique case (frame_q)
            FrIdle:  if (cs_fall) frame_d = FrCmd;
            FrCmd:   if (bit_rx && bit_cnt_q == 6'd7) frame_d = FrAddr;
            FrAddr:  if (bit_rx && bit_cnt_q == 6'd15) frame_d = FrData;
            FrData:  if (bit_rx && bit_cnt_q == 6'd31) frame_d = FrDone;
            FrDone:  frame_d = FrDone;
            default: frame_d = FrIdle;
        endcase
        if (cs_rise) frame_d = FrIdle;
    end

    // Pending write has priority: it always belongs to the older frame.
    always_comb begin
        bus_d    = bus_q;
        tmo_d    = tmo_q;
        load_wr  = 1'b0;
        load_rd  = 1'b0;
        cap_rd   = 1'b0;
        cap_zero = 1'b0;
        unique case (bus_q)
            BusIdle: begin
                tmo_d = '0;
                if (wr_pend_q) begin
                    load_wr = 1'b1;
                    bus_d   = BusWr;
                end else if (rd_pend_q && !cs_rise) begin
                    load_rd = 1'b1;
                    bus_d   = BusRd;
                end
            end
            BusRd: begin
                if (cs_rise) begin
                    bus_d = BusIdle;
                end else if (reg_ack) begin
                    cap_rd = 1'b1;
                    bus_d  = BusIdle;
                end else if (tmo_q == TmoW'(ACK_TIMEOUT - 1)) begin
                    cap_zero = 1'b1;
                    bus_d    = BusIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            BusWr: begin
                if (reg_ack || tmo_q == TmoW'(ACK_TIMEOUT - 1)) begin
                    bus_d = BusIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            default: bus_d = BusIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= FrIdle;
            bus_q   <= BusIdle;
            tmo_q   <= '0;
        end else begin
            frame_q <= frame_d;
            bus_q   <= bus_d;
            tmo_q   <= tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q    <= '0;
            rx_sr_q      <= '0;
            cmd_wr_q     <= 1'b0;
            frame_addr_q <= '0;
            rd_pend_q    <= 1'b0;
            wr_pend_q    <= 1'b0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            reg_addr_q   <= '0;
            reg_wdat_q   <= '0;
        end else begin
            if (cs_fall) begin
                bit_cnt_q <= '0;
                cmd_wr_q  <= 1'b0;
            end else if (bit_rx) begin
                bit_cnt_q <= bit_cnt_q + 6'd1;
                rx_sr_q   <= {rx_sr_q[DATA_W-3:0], mosi_s};
                if (bit_cnt_q == 6'd0) cmd_wr_q <= mosi_s;
                if (bit_cnt_q == 6'd15) frame_addr_q <= addr_now;
            end

            if (load_rd || cs_rise) rd_pend_q <= 1'b0;
            if (bit_rx && bit_cnt_q == 6'd15 && !cmd_wr_q) begin
                rd_pend_q <= 1'b1;
                rd_addr_q <= addr_now;
            end

            if (load_wr) wr_pend_q <= 1'b0;
            if (bit_rx && bit_cnt_q == 6'd31 && cmd_wr_q) begin
                wr_pend_q <= 1'b1;
                wr_addr_q <= frame_addr_q;
                wr_data_q <= {rx_sr_q, mosi_s};
            end

            if (load_wr) begin
                reg_addr_q <= wr_addr_q;
                reg_wdat_q <= wr_data_q;
            end else if (load_rd) begin
                reg_addr_q <= rd_addr_q;
            end
        end
    end

    // MISO stays 0 until read data (or the zero word after a timeout) is loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sr_q  <= '0;
            tx_vld_q <= 1'b0;
            miso_q   <= 1'b0;
        end else begin
            if (cs_fall || cs_rise) begin
                tx_sr_q  <= '0;
                tx_vld_q <= 1'b0;
                miso_q   <= 1'b0;
            end else if (sclk_fall) begin
                if (tx_vld_q && bit_cnt_q < 6'd32 && frame_q != FrIdle) begin
                    miso_q  <= tx_sr_q[DATA_W-1];
                    tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
                end else begin
                    miso_q <= 1'b0;
                end
            end
            if (cap_rd) begin
                tx_sr_q  <= reg_rdat;
                tx_vld_q <= 1'b1;
            end else if (cap_zero) begin
                tx_sr_q  <= '0;
                tx_vld_q <= 1'b1;
            end
        end
    end

    assign spi_miso = miso_q;
    assign reg_addr = reg_addr_q;
    assign reg_wdat = reg_wdat_q;
    assign reg_wr   = (bus_q == BusWr);
    assign reg_rd   = (bus_q == BusRd);

endmodule

// File: tb/tb_rtmc_spi_reg_bridge.sv
// Scoreboard bench for rtmc_spi_reg_bridge: a SPI driver pushes expected bus
// transactions and MISO words; monitors pop and compare as the DUT responds.
module tb_rtmc_spi_reg_bridge;

    localparam int HALF = 200;

    logic        clk, rst;
    logic        spi_sclk, spi_cs, spi_mosi, spi_miso;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdat, reg_rdat;
    logic        reg_wr, reg_rd, reg_ack;

    rtmc_spi_reg_bridge #(
        .ADDR_W(8),
        .DATA_W(16),
        .ACK_TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .spi_sclk(spi_sclk),
        .spi_cs(spi_cs),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .reg_addr(reg_addr),
        .reg_wdat(reg_wdat),
        .reg_wr(reg_wr),
        .reg_rd(reg_rd),
        .reg_rdat(reg_rdat),
        .reg_ack(reg_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [15:0] data;
        int          len;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] miso_exp_q[$];
    logic [31:0] miso_got_q[$];
    int          checks = 0;
    int          failures = 0;
    int          ack_delay = 0;
    bit          ack_en = 1'b1;
    logic [15:0] resp_data = '0;
    logic [31:0] miso_cap;

    task automatic expect_wr(input logic [7:0] a, input logic [15:0] d, input int len);
        txn_t t;
        t.wr = 1'b1; t.addr = a; t.data = d; t.len = len;
        exp_q.push_back(t);
    endtask

    task automatic expect_rd(input logic [7:0] a, input int len);
        txn_t t;
        t.wr = 1'b0; t.addr = a; t.data = '0; t.len = len;
        exp_q.push_back(t);
    endtask

    task automatic send_bit(input logic b);
        spi_mosi = b;
        #HALF;
        spi_sclk = 1'b1;
        miso_cap = {miso_cap[30:0], spi_miso};
        #HALF;
        spi_sclk = 1'b0;
    endtask

    task automatic cs_high();
        #HALF;
        spi_cs = 1'b1;
        #(2 * HALF);
    endtask

    task automatic frame(input logic [31:0] w, input int nbits, input bit chk);
        spi_cs   = 1'b0;
        miso_cap = '0;
        for (int i = 0; i < nbits; i++) send_bit(w[31-i]);
        cs_high();
        if (chk) miso_got_q.push_back(miso_cap);
    endtask

    // Responder: acks ack_delay cycles after first seeing a strobe.
    initial begin
        reg_ack  = 1'b0;
        reg_rdat = '0;
        forever begin
            @(posedge clk);
            #1;
            if ((reg_rd || reg_wr) && ack_en && !rst) begin
                repeat (ack_delay) @(posedge clk);
                #1;
                reg_ack  = 1'b1;
                reg_rdat = resp_data;
                @(posedge clk);
                #1;
                reg_ack  = 1'b0;
                reg_rdat = '0;
            end
        end
    end

    // Bus monitor: checks strobe kind/address/data at start and length at end.
    initial begin
        bit   act;
        int   len;
        txn_t cur;
        act = 1'b0;
        len = 0;
        cur.wr = 1'b0; cur.addr = '0; cur.data = '0; cur.len = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                act = 1'b0;
                continue;
            end
            if (reg_rd || reg_wr) begin
                if (!act) begin
                    act = 1'b1;
                    len = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_strobe got wr=%0b rd=%0b addr=%h, none required",
                                 reg_wr, reg_rd, reg_addr);
                        cur.len = -1;
                    end else begin
                        cur = exp_q.pop_front();
                        if (reg_wr !== cur.wr || reg_rd !== !cur.wr || reg_addr !== cur.addr ||
                            (cur.wr && reg_wdat !== cur.data)) begin
                            failures++;
                            $display("FAIL strobe_start got wr=%0b rd=%0b addr=%h wdat=%h want wr=%0b addr=%h wdat=%h",
                                     reg_wr, reg_rd, reg_addr, reg_wdat, cur.wr, cur.addr, cur.data);
                        end
                    end
                end
                len++;
            end else if (act) begin
                act = 1'b0;
                if (cur.len >= 0) begin
                    checks++;
                    if (len != cur.len) begin
                        failures++;
                        $display("FAIL strobe_len addr=%h got %0d cycles want %0d", cur.addr, len,
                                 cur.len);
                    end
                end
            end
        end
    end

    // MISO monitor
    initial begin
        logic [31:0] got, want;
        forever begin
            @(posedge clk);
            if (miso_got_q.size() > 0) begin
                got = miso_got_q.pop_front();
                checks++;
                if (miso_exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL miso_word got %h, none required", got);
                end else begin
                    want = miso_exp_q.pop_front();
                    if (got !== want) begin
                        failures++;
                        $display("FAIL miso_word got %h want %h", got, want);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog expired got timeout want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst      = 1'b1;
        spi_cs   = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({spi_miso, reg_wr, reg_rd, reg_addr, reg_wdat} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got miso=%b wr=%b rd=%b addr=%h wdat=%h want all 0",
                     spi_miso, reg_wr, reg_rd, reg_addr, reg_wdat);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Plain write, ack after 3 cycles
        ack_delay = 3;
        expect_wr(8'h12, 16'hBEEF, 4);
        miso_exp_q.push_back(32'h0);
        frame(32'h8012_BEEF, 32, 1'b1);

        // Read returning A5C3 after 2 cycles
        ack_delay = 2;
        resp_data = 16'hA5C3;
        expect_rd(8'h34, 3);
        miso_exp_q.push_back(32'h0000_A5C3);
        frame(32'h0034_0000, 32, 1'b1);

        // Truncated write: no strobe; then a normal write
        frame(32'h8077_DEAD, 20, 1'b0);
        ack_delay = 1;
        expect_wr(8'h56, 16'h1357, 2);
        miso_exp_q.push_back(32'h0);
        frame(32'h8056_1357, 32, 1'b1);

        // Read with no ack: timeout after 15 cycles, zero data; then a normal read
        ack_en = 1'b0;
        expect_rd(8'h9A, 15);
        miso_exp_q.push_back(32'h0);
        frame(32'h009A_0000, 32, 1'b1);
        ack_en    = 1'b1;
        ack_delay = 0;
        resp_data = 16'h0F0F;
        expect_rd(8'h9B, 1);
        miso_exp_q.push_back(32'h0000_0F0F);
        frame(32'h009B_0000, 32, 1'b1);

        // Reset during DATA of a write: no strobe, outputs cleared
        begin
            logic [31:0] w;
            w        = 32'h80C0_FFEE;
            spi_cs   = 1'b0;
            miso_cap = '0;
            for (int i = 0; i < 24; i++) send_bit(w[31-i]);
            @(negedge clk);
            rst = 1'b1;
            repeat (3) @(negedge clk);
            checks++;
            if ({spi_miso, reg_wr, reg_rd, reg_addr, reg_wdat} !== '0) begin
                failures++;
                $display("FAIL midframe_reset got miso=%b wr=%b rd=%b addr=%h wdat=%h want all 0",
                         spi_miso, reg_wr, reg_rd, reg_addr, reg_wdat);
            end
            rst = 1'b0;
            for (int i = 24; i < 32; i++) send_bit(w[31-i]);
            cs_high();
        end
        ack_delay = 2;
        resp_data = 16'h1234;
        expect_rd(8'h01, 3);
        miso_exp_q.push_back(32'h0000_1234);
        frame(32'h0001_0000, 32, 1'b1);

        // Back-to-back: slow-acked write then read, one sclk period gap
        ack_delay = 10;
        expect_wr(8'h40, 16'hCAFE, 11);
        miso_exp_q.push_back(32'h0);
        frame(32'h8040_CAFE, 32, 1'b1);
        ack_delay = 2;
        resp_data = 16'h5A5A;
        expect_rd(8'h41, 3);
        miso_exp_q.push_back(32'h0000_5A5A);
        frame(32'h0041_0000, 32, 1'b1);

        repeat (50) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || miso_exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d bus and %0d miso expectations left want 0 and 0",
                     exp_q.size(), miso_exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtmc_spi_reg_bridge.md
RTMC_SPI_REG_BRIDGE -- requirements
Module: rtmc_spi_reg_bridge

Interface
REQ-001 Parameter ADDR_W, default 8, register address width; SHALL be 8 in this revision.
REQ-002 Parameter DATA_W, default 16, register data width; SHALL be 16 in this revision.
REQ-003 Parameter ACK_TIMEOUT, default 15, maximum clk cycles a bus strobe is held without reg_ack.
REQ-004 Port clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port spi_sclk  input  1  SPI clock, mode 0, asynchronous to clk.
REQ-007 Port spi_cs  input  1  chip select, active low, asynchronous.
REQ-008 Port spi_mosi  input  1  controller-to-bridge serial data, MSB first.
REQ-009 Port spi_miso  output  1  bridge-to-controller serial data, MSB first.
REQ-010 Port reg_addr  output  ADDR_W  register address.
REQ-011 Port reg_wdat  output  DATA_W  write data.
REQ-012 Port reg_wr  output  1  write strobe, held until ack or timeout.
REQ-013 Port reg_rd  output  1  read strobe, held until ack or timeout.
REQ-014 Port reg_rdat  input  DATA_W  read data, valid when reg_ack=1.
REQ-015 Port reg_ack  input  1  responder acknowledge, single-cycle.

Function
REQ-016 spi_sclk, spi_cs, spi_mosi SHALL each pass a 2-flop synchronizer; edges detected on synchronized values; clk SHALL be >= 8x sclk frequency.
REQ-017 Frame = 32 bits while spi_cs low: bits 0-7 command (bit 7: 1=write, 0=read; bits 6:0 ignored), bits 8-15 address, bits 16-31 data.
REQ-018 MOSI SHALL be sampled on synchronized sclk rising edge; MISO SHALL update on synchronized sclk falling edge.
REQ-019 Frame FSM states: IDLE, CMD, ADDR, DATA, DONE; IDLE->CMD on cs falling; CMD->ADDR after 8 bits; ADDR->DATA after 16 bits; DATA->DONE after 32 bits; any state->IDLE on cs rising.
REQ-020 Bit counter SHALL be 6 bits and saturate at 32; bits beyond 32 SHALL be ignored, MISO SHALL output 0.
REQ-021 Bus FSM states: B_IDLE, B_RD, B_WR; reg_rd=1 only in B_RD, reg_wr=1 only in B_WR; never both.
REQ-022 Read: cycle after 16th bit sampled with command bit 7=0, reg_addr SHALL be loaded and bus FSM SHALL enter B_RD.
REQ-023 On reg_ack in B_RD, reg_rdat SHALL be loaded into 16-bit MISO shift register and bus FSM -> B_IDLE next cycle.
REQ-024 MISO SHALL output 0 during CMD and ADDR and until a read ack; first data bit (rdat[15]) SHALL appear on first sclk falling edge after the ack.
REQ-025 Write: cycle after 32nd bit sampled with command bit 7=1, reg_wdat SHALL hold bits 16-31 and bus FSM SHALL enter B_WR.
REQ-026 Frame terminated (cs rising) before 32 bits SHALL produce no write; cs rising during B_RD SHALL drop reg_rd next cycle with no data capture.
REQ-027 cs rising during B_WR SHALL NOT abort the write.
REQ-028 Timeout counter SHALL count cycles in B_RD/B_WR; at ACK_TIMEOUT without ack, strobe SHALL drop and FSM -> B_IDLE; read data SHALL then shift as 0x0000.
REQ-029 reg_ack in B_IDLE SHALL be ignored.
REQ-030 New frame starting while B_WR pending SHALL be accepted; its read/write SHALL be issued only after B_WR completes.

Reset
REQ-031 On rst: both FSMs idle, bit counter 0, shift registers 0, spi_miso=0, reg_addr=0, reg_wdat=0, reg_wr=0, reg_rd=0, timeout counter 0.
REQ-032 rst mid-frame or mid-strobe SHALL abort immediately; bridge SHALL ignore the remainder until next cs falling edge.

Verification
REQ-033 Write frame 0x80,0x12,0xBEEF, ack after 3 cycles -> reg_wr high exactly until ack, reg_addr=0x12, reg_wdat=0xBEEF, one write.
REQ-034 Read frame 0x00,0x34, responder returns 0xA5C3 after 2 cycles -> reg_rd held until ack, MISO bits 16-31 = 0xA5C3.
REQ-035 Write frame with cs raised after 20 bits -> no reg_wr pulse; next full write succeeds normally.
REQ-036 Read with no ack -> reg_rd drops after 15 cycles, MISO data = 0x0000, next frame works.
REQ-037 rst asserted during DATA of a write -> all outputs 0, no reg_wr; following read of 0x01 returns correct data.
REQ-038 Back-to-back write then read with cs gap of 1 sclk period, slow ack on write -> write completes first, read then issued, no strobe overlap.
